// File: rtl/fifo_test_pkg.sv
// Shared definitions for the FIFO test slice: sequencer state encodings,
// handshake phases, default length and timeout widths.
package fifo_test_pkg;

   localparam int unsigned LEN_W = 12;
   localparam int unsigned TO_W  = 24;

   localparam logic [LEN_W-1:0] LEN_MAX_DEF = 12'hC;
   localparam logic [TO_W-1:0]  TIMEOUT_DEF = 24'hFFFFFF;

   // Sequencer states; the numeric values are shown on the status LEDs.
   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_WR_REQ = 3'd1,
      S_WR_REL = 3'd2,
      S_RD_REQ = 3'd3,
      S_RD_REL = 3'd4,
      S_DONE   = 3'd5,
      S_ERR    = 3'd6
   } seq_state_t;

   // Phases of one 4-phase fs/fd handshake.
   typedef enum logic [1:0] {
      H_IDLE = 2'd0,
      H_REQ  = 2'd1,
      H_REL  = 2'd2
   } hs_phase_t;

endpackage

// File: rtl/fifo_seq_ctrl_hs_master.sv
// Generic 4-phase fs/fd handshake master with a per-phase timeout.
// ack/done/timeout are same-cycle indications so the sequencer can change
// state on the very edge the handshake advances.
module hs_master
   import fifo_test_pkg::*;
#(
   parameter logic [TO_W-1:0] TIMEOUT = TIMEOUT_DEF
) (
   input  logic clk,
   input  logic rst,
   input  logic go,
   input  logic fd,
   output logic fs,
   output logic ack,
   output logic done,
   output logic timeout
);

   localparam logic [TO_W-1:0] TO_LIM = TIMEOUT - TO_W'(1);

   hs_phase_t       phase;
   logic [TO_W-1:0] cnt;

   // Handshake progress indications; a real transition always beats a timeout.
   always_comb begin
      ack     = 1'b0;
      done    = 1'b0;
      timeout = 1'b0;
      ack     = (phase == H_REQ) && fs && fd;
      done    = (phase == H_REL) && !fd;
      timeout = (phase != H_IDLE) && !ack && !done && (cnt == TO_LIM);
   end

   // Phase register, registered fs and the per-phase timeout counter.
   // fs is held back while fd is still high so it never re-rises over a stale done.
   always_ff @(posedge clk) begin
      if (rst) begin
         phase <= H_IDLE;
         fs    <= 1'b0;
         cnt   <= '0;
      end else begin
         case (phase)
            H_IDLE: begin
               cnt <= '0;
               if (go) begin
                  phase <= H_REQ;
                  fs    <= !fd;
               end
            end
            H_REQ: begin
               if (ack) begin
                  phase <= H_REL;
                  fs    <= 1'b0;
                  cnt   <= '0;
               end else if (timeout) begin
                  phase <= H_IDLE;
                  fs    <= 1'b0;
                  cnt   <= '0;
               end else begin
                  if (!fs && !fd) begin
                     fs <= 1'b1;
                  end
                  cnt <= cnt + TO_W'(1);
               end
            end
            H_REL: begin
               if (done || timeout) begin
                  phase <= H_IDLE;
                  cnt   <= '0;
               end else begin
                  cnt <= cnt + TO_W'(1);
               end
            end
            default: begin
               phase <= H_IDLE;
               fs    <= 1'b0;
               cnt   <= '0;
            end
         endcase
      end
   end

endmodule

// File: rtl/fifo_seq_ctrl.sv
// Round sequencer for the FIFO test: launches a write handshake then a read
// handshake per key_go pulse, manages the transfer length and reports status.
module fifo_seq_ctrl
   import fifo_test_pkg::*;
#(
   parameter logic [LEN_W-1:0] LEN_MAX = LEN_MAX_DEF,
   parameter logic [TO_W-1:0]  TIMEOUT = TIMEOUT_DEF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        key_go,
   input  logic        key_len,
   output logic        fs_fw,
   input  logic        fd_fw,
   output logic        fs_fr,
   input  logic        fd_fr,
   output logic [11:0] data_len,
   output logic        busy,
   output logic        err,
   output logic [7:0]  rounds,
   output logic [2:0]  state
);

   seq_state_t st;

   logic go_wr;
   logic go_rd;
   logic wr_ack;
   logic wr_done;
   logic wr_to;
   logic rd_ack;
   logic rd_done;
   logic rd_to;

   // Handshake launches: write on a start key in IDLE, read once the write has released.
   always_comb begin
      go_wr = 1'b0;
      go_rd = 1'b0;
      go_wr = (st == S_IDLE) && key_go;
      go_rd = (st == S_WR_REL) && wr_done;
   end

   hs_master #(
      .TIMEOUT (TIMEOUT)
   ) u_hs_wr (
      .clk     (clk),
      .rst     (rst),
      .go      (go_wr),
      .fd      (fd_fw),
      .fs      (fs_fw),
      .ack     (wr_ack),
      .done    (wr_done),
      .timeout (wr_to)
   );

   hs_master #(
      .TIMEOUT (TIMEOUT)
   ) u_hs_rd (
      .clk     (clk),
      .rst     (rst),
      .go      (go_rd),
      .fd      (fd_fr),
      .fs      (fs_fr),
      .ack     (rd_ack),
      .done    (rd_done),
      .timeout (rd_to)
   );

   // Sequencer FSM with registered busy/err, round counter and length register.
   always_ff @(posedge clk) begin
      if (rst) begin
         st       <= S_IDLE;
         busy     <= 1'b0;
         err      <= 1'b0;
         rounds   <= '0;
         data_len <= LEN_MAX;
      end else begin
         case (st)
            S_IDLE: begin
               if (key_go) begin
                  st   <= S_WR_REQ;
                  busy <= 1'b1;
               end else if (key_len) begin
                  if (data_len <= LEN_W'(1)) begin
                     data_len <= LEN_MAX;
                  end else begin
                     data_len <= data_len - LEN_W'(1);
                  end
               end
            end
            S_WR_REQ: begin
               if (wr_ack) begin
                  st <= S_WR_REL;
               end else if (wr_to) begin
                  st   <= S_ERR;
                  busy <= 1'b0;
                  err  <= 1'b1;
               end
            end
            S_WR_REL: begin
               if (wr_done) begin
                  st <= S_RD_REQ;
               end else if (wr_to) begin
                  st   <= S_ERR;
                  busy <= 1'b0;
                  err  <= 1'b1;
               end
            end
            S_RD_REQ: begin
               if (rd_ack) begin
                  st <= S_RD_REL;
               end else if (rd_to) begin
                  st   <= S_ERR;
                  busy <= 1'b0;
                  err  <= 1'b1;
               end
            end
            S_RD_REL: begin
               if (rd_done) begin
                  st <= S_DONE;
               end else if (rd_to) begin
                  st   <= S_ERR;
                  busy <= 1'b0;
                  err  <= 1'b1;
               end
            end
            S_DONE: begin
               rounds <= rounds + 8'd1;
               busy   <= 1'b0;
               st     <= S_IDLE;
            end
            S_ERR: begin
               if (key_go) begin
                  st  <= S_IDLE;
                  err <= 1'b0;
               end
            end
            default: begin
               st   <= S_IDLE;
               busy <= 1'b0;
            end
         endcase
      end
   end

   assign state = st;

endmodule

// File: tb/tb_fifo_seq_ctrl.sv
// Bench for fifo_seq_ctrl: table-driven length/start vectors plus hand-written
// round, timeout, reset and wrap sequences against a simple engine model.
module tb_fifo_seq_ctrl;

   logic        clk;
   logic        rst;
   logic        key_go;
   logic        key_len;
   logic        fs_fw;
   logic        fd_fw;
   logic        fs_fr;
   logic        fd_fr;
   logic [11:0] data_len;
   logic        busy;
   logic        err;
   logic [7:0]  rounds;
   logic [2:0]  state;

   logic        eng_en;
   int          checks;
   int          errors;

   typedef struct {
      logic        go;
      logic        len;
      logic [2:0]  st;
      logic [11:0] dl;
      logic        bsy;
      logic        fsw;
   } vec_t;

   vec_t vecs[15];

   fifo_seq_ctrl #(
      .LEN_MAX (12'hC),
      .TIMEOUT (24'd16)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .key_go   (key_go),
      .key_len  (key_len),
      .fs_fw    (fs_fw),
      .fd_fw    (fd_fw),
      .fs_fr    (fs_fr),
      .fd_fr    (fd_fr),
      .data_len (data_len),
      .busy     (busy),
      .err      (err),
      .rounds   (rounds),
      .state    (state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Engine model: fd rises 5 cycles after fs is seen, drops 1 cycle after fs falls.
   initial begin : engines
      int wcnt;
      int rcnt;
      wcnt  = 0;
      rcnt  = 0;
      fd_fw = 1'b0;
      fd_fr = 1'b0;
      forever begin
         @(posedge clk);
         #2;
         if (rst) begin
            fd_fw = 1'b0;
            fd_fr = 1'b0;
            wcnt  = 0;
            rcnt  = 0;
         end else if (eng_en) begin
            if (fs_fw && !fd_fw) begin
               if (wcnt == 5) begin
                  fd_fw = 1'b1;
                  wcnt  = 0;
               end else begin
                  wcnt++;
               end
            end else begin
               wcnt = 0;
               if (!fs_fw && fd_fw) fd_fw = 1'b0;
            end
            if (fs_fr && !fd_fr) begin
               if (rcnt == 5) begin
                  fd_fr = 1'b1;
                  rcnt  = 0;
               end else begin
                  rcnt++;
               end
            end else begin
               rcnt = 0;
               if (!fs_fr && fd_fr) fd_fr = 1'b0;
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic pulse_go();
      key_go = 1'b1;
      tick();
      key_go = 1'b0;
   endtask

   task automatic wait_state(input logic [2:0] tgt, input int budget, output int cyc);
      cyc = 0;
      while (state != tgt && cyc < budget) begin
         tick();
         cyc++;
      end
   endtask

   initial begin : main
      int cyc;
      checks  = 0;
      errors  = 0;
      rst     = 1'b1;
      key_go  = 1'b0;
      key_len = 1'b0;
      eng_en  = 1'b1;

      for (int i = 0; i < 11; i++)
         vecs[i] = '{1'b0, 1'b1, 3'd0, 12'(11 - i), 1'b0, 1'b0};
      vecs[11] = '{1'b0, 1'b1, 3'd0, 12'd12, 1'b0, 1'b0};
      vecs[12] = '{1'b1, 1'b1, 3'd1, 12'd12, 1'b1, 1'b1};
      vecs[13] = '{1'b0, 1'b1, 3'd1, 12'd12, 1'b1, 1'b1};
      vecs[14] = '{1'b1, 1'b0, 3'd1, 12'd12, 1'b1, 1'b1};

      // Reset and idle
      repeat (3) tick();
      rst = 1'b0;
      repeat (10) tick();
      check("rst_fs_fw", 32'(fs_fw), 32'd0);
      check("rst_fs_fr", 32'(fs_fr), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_err", 32'(err), 32'd0);
      check("rst_rounds", 32'(rounds), 32'd0);
      check("rst_len", 32'(data_len), 32'd12);
      check("rst_state", 32'(state), 32'd0);

      // One full round
      pulse_go();
      check("go_fs_fw", 32'(fs_fw), 32'd1);
      check("go_state", 32'(state), 32'd1);
      check("go_busy", 32'(busy), 32'd1);
      wait_state(3'd3, 60, cyc);
      check("rdreq_cycles", 32'(cyc), 32'd7);
      check("rdreq_fs_fr", 32'(fs_fr), 32'd1);
      check("rdreq_fd_fw", 32'(fd_fw), 32'd0);
      wait_state(3'd5, 60, cyc);
      check("done_cycles", 32'(cyc), 32'd7);
      check("done_busy", 32'(busy), 32'd1);
      check("done_rounds", 32'(rounds), 32'd0);
      tick();
      check("post_state", 32'(state), 32'd0);
      check("post_busy", 32'(busy), 32'd0);
      check("post_rounds", 32'(rounds), 32'd1);

      // Length table, then start+len together and keys while busy
      for (int i = 0; i < 15; i++) begin
         key_go  = vecs[i].go;
         key_len = vecs[i].len;
         tick();
         key_go  = 1'b0;
         key_len = 1'b0;
         check($sformatf("vec%0d_state", i), 32'(state), 32'(vecs[i].st));
         check($sformatf("vec%0d_len", i), 32'(data_len), 32'(vecs[i].dl));
         check($sformatf("vec%0d_busy", i), 32'(busy), 32'(vecs[i].bsy));
         check($sformatf("vec%0d_fs_fw", i), 32'(fs_fw), 32'(vecs[i].fsw));
      end
      wait_state(3'd5, 60, cyc);
      check("r2_reach_done", 32'(cyc < 60), 32'd1);
      tick();
      check("r2_rounds", 32'(rounds), 32'd2);
      repeat (20) tick();
      check("r2_no_queue_state", 32'(state), 32'd0);
      check("r2_no_queue_rounds", 32'(rounds), 32'd2);

      // Write-phase timeout
      eng_en = 1'b0;
      pulse_go();
      check("to_fs_fw_rise", 32'(fs_fw), 32'd1);
      repeat (15) tick();
      check("to_err_early", 32'(err), 32'd0);
      check("to_state_early", 32'(state), 32'd1);
      tick();
      check("to_err", 32'(err), 32'd1);
      check("to_state", 32'(state), 32'd6);
      check("to_fs_fw", 32'(fs_fw), 32'd0);
      check("to_busy", 32'(busy), 32'd0);
      key_len = 1'b1;
      tick();
      key_len = 1'b0;
      check("err_len_hold", 32'(data_len), 32'd12);
      pulse_go();
      check("clr_state", 32'(state), 32'd0);
      check("clr_err", 32'(err), 32'd0);
      check("clr_rounds", 32'(rounds), 32'd2);

      // Reset mid-round in RD_REQ
      eng_en = 1'b1;
      pulse_go();
      wait_state(3'd3, 60, cyc);
      check("mid_reach_rdreq", 32'(cyc < 60), 32'd1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("mid_fs_fr", 32'(fs_fr), 32'd0);
      check("mid_state", 32'(state), 32'd0);
      check("mid_rounds", 32'(rounds), 32'd0);
      check("mid_busy", 32'(busy), 32'd0);
      tick();

      // 256 rounds wrap the counter
      for (int r = 0; r < 256; r++) begin
         pulse_go();
         wait_state(3'd5, 60, cyc);
         if (cyc >= 60) begin
            check($sformatf("wrap_round%0d_done", r), 32'(cyc < 60), 32'd1);
            break;
         end
         tick();
         if (r == 254) check("wrap_255", 32'(rounds), 32'd255);
      end
      check("wrap_0", 32'(rounds), 32'd0);
      check("wrap_state", 32'(state), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
